// File: rtl/mont_domain_convert_if.sv
// Request/result bundle between a host and the Montgomery-domain converter.
// Master drives the operand request, slave returns busy/valid/result.
interface mont_domain_convert_if #(
  parameter int DATA_LENGTH = 64
);
  logic                   start_i;
  logic [DATA_LENGTH-1:0] x_i;
  logic [DATA_LENGTH-1:0] q_i;
  logic [DATA_LENGTH-1:0] q_bl_i;
  logic                   busy_o;
  logic                   valid_o;
  logic [DATA_LENGTH-1:0] x_m_o;

  modport master (
    output start_i, x_i, q_i, q_bl_i,
    input  busy_o, valid_o, x_m_o
  );

  modport slave (
    input  start_i, x_i, q_i, q_bl_i,
    output busy_o, valid_o, x_m_o
  );
endinterface

// File: rtl/mont_domain_convert.sv
// Bit-serial x -> x*2^q_bl mod q converter: MSB-first reduce of x,
// then k modular doublings, one conditional subtract per cycle.
module mont_domain_convert #(
  parameter int DATA_LENGTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mont_domain_convert_if.slave  bus
);
  localparam int DL = DATA_LENGTH;
  localparam int KW = $clog2(DL + 1);
  localparam int IW = $clog2(DL);
  localparam logic [DL-1:0] DL_V = DL[DL-1:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDUCE,
    S_SCALE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [DL-1:0] r_x;
  logic [DL-1:0] r_q;
  logic [DL-1:0] r_acc;
  logic [DL-1:0] r_xm;
  logic [KW-1:0] r_k;
  logic [IW-1:0] r_idx;
  logic          r_valid;

  logic          w_load;
  logic          w_write;
  logic          w_bit;
  logic [KW-1:0] w_k_in;
  logic [DL:0]   w_t;
  logic [DL-1:0] w_diff;
  logic [DL-1:0] w_red;

  assign w_k_in = (bus.q_bl_i > DL_V) ? KW'(DL)
                                      : bus.q_bl_i[KW-1:0];

  // acc < q keeps t < 2q, so one subtract restores the invariant
  assign w_bit  = (r_state == S_REDUCE) ? r_x[r_idx] : 1'b0;
  assign w_t    = {r_acc, w_bit};
  assign w_diff = w_t[DL-1:0] - r_q;
  assign w_red  = (w_t >= {1'b0, r_q}) ? w_diff : w_t[DL-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_write     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_load      = 1'b1;
          w_state_nxt = S_REDUCE;
        end
      end
      S_REDUCE: begin
        if (r_idx == '0) begin
          if (r_k != '0) begin
            w_state_nxt = S_SCALE;
          end else begin
            w_write     = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_SCALE: begin
        if (r_k <= KW'(1)) begin
          w_write     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_q     <= '0;
      r_acc   <= '0;
      r_xm    <= '0;
      r_k     <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_write;
      if (w_load) begin
        r_x   <= bus.x_i;
        r_q   <= bus.q_i;
        r_k   <= w_k_in;
        r_acc <= '0;
        r_idx <= IW'(DL - 1);
      end else if (r_state == S_REDUCE) begin
        r_acc <= w_red;
        r_idx <= r_idx - 1'b1;
      end else if (r_state == S_SCALE) begin
        r_acc <= w_red;
        r_k   <= r_k - 1'b1;
      end
      if (w_write) begin
        r_xm <= w_red;
      end
    end
  end

  assign bus.busy_o  = (r_state != S_IDLE);
  assign bus.valid_o = r_valid;
  assign bus.x_m_o   = r_xm;
endmodule
